// File: rtl/seqdet_frame_ctrl.sv
// rtl/seqdet_frame_ctrl.sv - serial sync-word detector with payload capture and ready/valid hold
module seqdet_frame_ctrl #(
    parameter int PAT_W = 4,
    parameter int PAY_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic             i_data,
    input  logic             i_bit_valid,
    output logic [PAY_W-1:0] o_payload,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_hunting,
    output logic             o_drop,
    output logic [7:0]       o_frames
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HUNT    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int CNT_W  = (PAY_W > 1) ? $clog2(PAY_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PAY_W - 1);

    logic [1:0]        state_q,   state_d;
    logic [PAT_W-1:0]  hist_q,    hist_d;
    logic [FILL_W-1:0] fill_q,    fill_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [PAY_W-1:0]  payload_q, payload_d;
    logic              valid_q,   valid_d;
    logic              hunting_q, hunting_d;
    logic              drop_q,    drop_d;
    logic [7:0]        frames_q,  frames_d;

    logic [PAT_W-1:0]  hist_next;

    assign hist_next = {hist_q[PAT_W-2:0], i_data};

    // Next-state and datapath: disable dominates, then per-state behaviour gated by i_bit_valid
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        bit_cnt_d = bit_cnt_q;
        payload_d = payload_q;
        valid_d   = valid_q;
        drop_d    = 1'b0;
        frames_d  = frames_q;

        if (!i_enable) begin
            // Any partial or held frame is abandoned; the frame count survives.
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_HUNT;
                    hist_d  = '0;
                    fill_d  = '0;
                end
                S_HUNT: begin
                    if (i_bit_valid) begin
                        hist_d = hist_next;
                        if (fill_q != FILL_MAX) begin
                            fill_d = fill_q + 1'b1;
                        end
                        // Fill must already hold PAT_W-1 real bits so stale zeros never match.
                        if ((fill_q >= FILL_THR) && (hist_next == i_pattern)) begin
                            state_d   = S_PAYLOAD;
                            bit_cnt_d = '0;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (i_bit_valid) begin
                        payload_d = {payload_q[PAY_W-2:0], i_data};
                        if (bit_cnt_q == CNT_LAST) begin
                            state_d = S_HOLD;
                            valid_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    // HOLD: payload frozen; incoming bits are dropped, including on the handshake edge.
                    if (i_bit_valid) begin
                        drop_d = 1'b1;
                    end
                    if (valid_q && i_ready) begin
                        valid_d  = 1'b0;
                        frames_d = frames_q + 8'd1;
                        state_d  = S_HUNT;
                        hist_d   = '0;
                        fill_d   = '0;
                    end
                end
            endcase
        end

        hunting_d = (state_d == S_HUNT);
    end

    // State and output registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            bit_cnt_q <= '0;
            payload_q <= '0;
            valid_q   <= 1'b0;
            hunting_q <= 1'b0;
            drop_q    <= 1'b0;
            frames_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            bit_cnt_q <= bit_cnt_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            hunting_q <= hunting_d;
            drop_q    <= drop_d;
            frames_q  <= frames_d;
        end
    end

    assign o_payload = payload_q;
    assign o_valid   = valid_q;
    assign o_hunting = hunting_q;
    assign o_drop    = drop_q;
    assign o_frames  = frames_q;

endmodule

// File: tb/tb_seqdet_frame_ctrl.sv
// tb/tb_seqdet_frame_ctrl.sv - scoreboard bench for seqdet_frame_ctrl
module tb_seqdet_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_enable;
    logic [3:0] i_pattern;
    logic       i_data;
    logic       i_bit_valid;
    logic [7:0] o_payload;
    logic       o_valid;
    logic       i_ready;
    logic       o_hunting;
    logic       o_drop;
    logic [7:0] o_frames;

    typedef struct {
        logic [7:0] pay;
        logic [7:0] frames;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   drop_seen = 0;

    seqdet_frame_ctrl #(.PAT_W(4), .PAY_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_enable    (i_enable),
        .i_pattern   (i_pattern),
        .i_data      (i_data),
        .i_bit_valid (i_bit_valid),
        .o_payload   (o_payload),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_hunting   (o_hunting),
        .o_drop      (o_drop),
        .o_frames    (o_frames)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] pay, input logic [7:0] frames);
        exp_t e;
        e.pay    = pay;
        e.frames = frames;
        exp_q.push_back(e);
    endtask

    // Bits MSB-first from vec[n-1]; gap inserts an invalid cycle with inverted data after each bit.
    task automatic send_bits(input logic [15:0] vec, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            @(posedge clk); #1;
            i_data      = vec[i];
            i_bit_valid = 1'b1;
            if (gap) begin
                @(posedge clk); #1;
                i_bit_valid = 1'b0;
                i_data      = ~vec[i];
            end
        end
        if (!gap) begin
            @(posedge clk); #1;
            i_bit_valid = 1'b0;
        end
    endtask

    // o_valid must be up one cycle after the last bit; with i_ready=1 the next edge hands off.
    task automatic finish_frame(input string name, input logic [7:0] frames_after);
        @(negedge clk);
        chk({name, "_valid"}, o_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, "_valid_clr"}, o_valid, 0);
        chk({name, "_frames"}, o_frames, frames_after);
        chk({name, "_hunting"}, o_hunting, 1);
    endtask

    initial begin
        reset       = 1'b1;
        i_enable    = 1'b1;
        i_pattern   = 4'b1101;
        i_data      = 1'b0;
        i_bit_valid = 1'b0;
        i_ready     = 1'b1;

        fork
            // Monitor: pops the scoreboard on every handshake and counts drop pulses
            forever begin
                @(negedge clk);
                if (o_drop) drop_seen++;
                if (o_valid && i_ready && !reset && i_enable) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", {24'd0, o_payload}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("sb_payload", o_payload, e.pay);
                        chk("sb_frames", o_frames, e.frames);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_payload", o_payload, 0);
        chk("rst_hunting", o_hunting, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_frames", o_frames, 0);

        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("enter_hunt", o_hunting, 1);

        // Basic frame
        push(8'hA5, 8'd0);
        send_bits({4'b1101, 8'hA5}, 12, 1'b0);
        finish_frame("t1", 8'd1);

        // Sync word preceded by extra ones
        push(8'h3C, 8'd1);
        send_bits({6'b111101, 8'h3C}, 14, 1'b0);
        finish_frame("t2", 8'd2);

        // Back-pressure with bits arriving in HOLD
        i_ready = 1'b0;
        push(8'hC3, 8'd2);
        send_bits({4'b1101, 8'hC3}, 12, 1'b0);
        begin
            int base;
            base = drop_seen;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                i_bit_valid = (i % 2 == 0);
                i_data      = 1'($urandom);
                @(negedge clk);
                chk("t3_hold_valid", o_valid, 1);
                chk("t3_hold_payload", o_payload, 8'hC3);
            end
            @(posedge clk); #1;
            i_bit_valid = 1'b0;
            i_ready     = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk("t3_drops", drop_seen - base, 3);
            chk("t3_valid_clr", o_valid, 0);
            chk("t3_frames", o_frames, 8'd3);
            chk("t3_hunting", o_hunting, 1);
        end

        // Gapped bit stream
        push(8'h96, 8'd3);
        send_bits({4'b1101, 8'h96}, 12, 1'b1);
        finish_frame("t4", 8'd4);

        // Disable mid-payload, then a fresh frame
        send_bits({4'b1101, 4'b1010}, 8, 1'b0);
        @(posedge clk); #1;
        i_enable = 1'b0;
        @(negedge clk);
        chk("t5_dis_hunting", o_hunting, 0);
        chk("t5_dis_valid", o_valid, 0);
        @(posedge clk); #1;
        i_enable = 1'b1;
        push(8'hE7, 8'd4);
        send_bits({4'b1101, 8'hE7}, 12, 1'b0);
        finish_frame("t5", 8'd5);

        // Reset in HOLD with i_ready high on the same edge
        i_ready = 1'b0;
        send_bits({4'b1101, 8'h0F}, 12, 1'b0);
        @(negedge clk);
        chk("t6_hold_valid", o_valid, 1);
        @(posedge clk); #1;
        reset   = 1'b1;
        i_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_valid", o_valid, 0);
        chk("t6_frames", o_frames, 0);
        chk("t6_hunting", o_hunting, 0);
        chk("t6_payload", o_payload, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_frames_after", o_frames, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
